// File: rtl/muldiv_unit_pkg.sv
// Shared funct codes, FSM states and latched op control for the HI/LO mult/div unit.
package muldiv_unit_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  // MIPS SPECIAL funct codes (shared with the ALU decoder)
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Operation context captured at launch, consumed by the sign fix-up
  typedef struct packed {
    logic is_div;
    logic dz;
    logic neg_a;
    logic neg_b;
  } op_ctl_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// Unsigned iterative datapath: shift-add multiply / restoring divide, one bit per step.
module muldiv_unit_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_cnt_zero
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_nxt;

  // One multiply step: conditionally add multiplicand to upper half, shift right
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  always_comb begin
    w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_rem_sh - {1'b0, r_opnd};
    w_div_nxt = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                              : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  end

  // Accumulator, operand and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
      r_opnd   <= i_is_div ? i_b : i_a;
      r_is_div <= i_is_div;
      r_cnt    <= CNT_W'(WIDTH - 1);
    end else if (i_step) begin
      r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_acc      = r_acc;
  assign o_cnt_zero = (r_cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: FSM, sign handling, fix-up, HI/LO and handshake.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             r_state, w_state_nxt;
  op_ctl_t            r_ctl, w_ctl_in;
  logic               r_busy, r_done, r_dz;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_accept, w_mt_hi, w_mt_lo, w_step, w_write;
  logic               w_b_zero, w_cnt_zero;
  logic [WIDTH-1:0]   w_ld_a, w_ld_b;
  logic [2*WIDTH-1:0] w_acc, w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;

  // Launch context: magnitudes for signed ops, raw dividend kept for divide-by-zero
  always_comb begin
    w_b_zero        = (b == '0);
    w_ctl_in.is_div = is_div_op(op);
    w_ctl_in.dz     = is_div_op(op) && w_b_zero;
    w_ctl_in.neg_a  = is_signed_op(op) && a[WIDTH-1];
    w_ctl_in.neg_b  = is_signed_op(op) && b[WIDTH-1];
    w_ld_a = (w_ctl_in.neg_a && !w_ctl_in.dz) ? -a : a;
    w_ld_b = w_ctl_in.neg_b ? -b : b;
  end

  // Next-state and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    w_step      = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !cancel) begin
          if (is_muldiv(op)) begin
            w_accept    = 1'b1;
            w_state_nxt = w_ctl_in.dz ? ST_FIX : ST_CALC;
          end else if (op == FN_MTHI) begin
            w_mt_hi = 1'b1;
          end else if (op == FN_MTLO) begin
            w_mt_lo = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (w_cnt_zero) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        if (!cancel) w_write = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  muldiv_unit_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_is_div   (w_ctl_in.is_div),
    .i_a        (w_ld_a),
    .i_b        (w_ld_b),
    .o_acc      (w_acc),
    .o_cnt_zero (w_cnt_zero)
  );

  // Sign fix-up: product sign a^b, quotient sign a^b, remainder follows dividend
  always_comb begin
    w_prod = (r_ctl.neg_a ^ r_ctl.neg_b) ? -w_acc : w_acc;
    w_quo  = (r_ctl.neg_a ^ r_ctl.neg_b) ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    w_rem  = r_ctl.neg_a ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    if (r_ctl.dz) begin
      w_hi_res = w_acc[WIDTH-1:0];
      w_lo_res = '1;
    end else if (r_ctl.is_div) begin
      w_hi_res = w_rem;
      w_lo_res = w_quo;
    end else begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end
  end

  // Handshake flags, HI/LO and latched op context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_ctl  <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_write;
      if (w_accept) begin
        r_ctl <= w_ctl_in;
        r_dz  <= 1'b0;
      end
      if (w_mt_hi) r_hi <= a;
      if (w_mt_lo) r_lo <= a;
      if (w_write) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
        if (r_ctl.dz) r_dz <= 1'b1;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
